// File: rtl/fixed_predictor_encoder_if.sv
// Sample-in / residual-out stream bundle for the fixed-predictor encoder.
//
// Valid semantics: a sample transfers on every rising clock edge where
// iValid is high. There is no ready/backpressure: the encoder accepts every
// valid input. The consumer must likewise take every cycle that has oValid
// high. iFirst and iOrder carry meaning only when iValid is high.
interface fixed_predictor_encoder_if #(
    parameter int SAMPLE_WIDTH = 16
);
    localparam int RES_WIDTH = SAMPLE_WIDTH + 4;

    logic                          iValid;
    logic                          iFirst;
    logic [2:0]                    iOrder;
    logic signed [SAMPLE_WIDTH-1:0] iSample;

    logic                          oValid;
    logic                          oFirst;
    logic                          oWarmup;
    logic signed [RES_WIDTH-1:0]   oResidual;

    // Upstream framer side.
    modport master (
        output iValid, iFirst, iOrder, iSample,
        input  oValid, oFirst, oWarmup, oResidual
    );

    // Encoder side.
    modport slave (
        input  iValid, iFirst, iOrder, iSample,
        output oValid, oFirst, oWarmup, oResidual
    );
endinterface

// File: rtl/fixed_predictor_encoder.sv
// FLAC fixed-predictor residual encoder, orders 0-4 selected per block.
// Four register stages: capture, partial terms, sum, output.
// Warm-up samples are flagged and passed through sign-extended.
module fixed_predictor_encoder #(
    parameter int SAMPLE_WIDTH = 16
) (
    input  logic                      iClock,
    input  logic                      iReset,
    fixed_predictor_encoder_if.slave  bus_if
);
    localparam int RES_WIDTH = SAMPLE_WIDTH + 4;

    function automatic logic signed [RES_WIDTH-1:0] sext(input logic signed [SAMPLE_WIDTH-1:0] v);
        return {{(RES_WIDTH-SAMPLE_WIDTH){v[SAMPLE_WIDTH-1]}}, v};
    endfunction

    // Per-block state
    logic [2:0]                     order_q, order_d;
    logic [2:0]                     cnt_q, cnt_d;
    logic signed [SAMPLE_WIDTH-1:0] hist_q [1:4];
    logic signed [SAMPLE_WIDTH-1:0] hist_d [1:4];

    // State as seen by the sample currently presented (after block start)
    logic [2:0]                     cur_order;
    logic [2:0]                     cur_cnt;
    logic                           cur_warm;
    logic signed [SAMPLE_WIDTH-1:0] cur_hist [1:4];

    // Stage 0: captured sample plus its history
    logic                           s0_valid_q, s0_first_q, s0_warm_q;
    logic [2:0]                     s0_order_q;
    logic signed [SAMPLE_WIDTH-1:0] s0_x_q [0:4];

    // Stage 1: signed partial terms
    logic signed [RES_WIDTH-1:0]    xe [0:4];
    logic signed [RES_WIDTH-1:0]    t_d [0:4];
    logic                           s1_valid_q, s1_first_q, s1_warm_q;
    logic signed [RES_WIDTH-1:0]    s1_t_q [0:4];

    // Stage 2: sum
    logic                           s2_valid_q, s2_first_q, s2_warm_q;
    logic signed [RES_WIDTH-1:0]    s2_sum_q;

    // Stage 3: output register
    logic                           out_valid_q, out_first_q, out_warm_q;
    logic signed [RES_WIDTH-1:0]    out_res_q;

    // Resolve block start, warm-up status and the next block state.
    always_comb begin
        cur_order = order_q;
        cur_cnt   = cnt_q;
        for (int i = 1; i <= 4; i++) cur_hist[i] = hist_q[i];
        if (bus_if.iValid && bus_if.iFirst) begin
            cur_order = (bus_if.iOrder > 3'd4) ? 3'd4 : bus_if.iOrder;
            cur_cnt   = cur_order;
            for (int i = 1; i <= 4; i++) cur_hist[i] = '0;
        end
        cur_warm = (cur_cnt != 3'd0);

        order_d = order_q;
        cnt_d   = cnt_q;
        for (int i = 1; i <= 4; i++) hist_d[i] = hist_q[i];
        if (bus_if.iValid) begin
            order_d   = cur_order;
            cnt_d     = cur_warm ? (cur_cnt - 3'd1) : cur_cnt;
            hist_d[1] = bus_if.iSample;
            hist_d[2] = cur_hist[1];
            hist_d[3] = cur_hist[2];
            hist_d[4] = cur_hist[3];
        end
    end

    // Block state and stage-0 capture; idle cycles leave block state alone.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            order_q    <= '0;
            cnt_q      <= '0;
            s0_valid_q <= 1'b0;
            s0_first_q <= 1'b0;
            s0_warm_q  <= 1'b0;
            s0_order_q <= '0;
            for (int i = 1; i <= 4; i++) hist_q[i] <= '0;
            for (int i = 0; i <= 4; i++) s0_x_q[i] <= '0;
        end else begin
            order_q    <= order_d;
            cnt_q      <= cnt_d;
            for (int i = 1; i <= 4; i++) hist_q[i] <= hist_d[i];
            s0_valid_q <= bus_if.iValid;
            if (bus_if.iValid) begin
                s0_first_q <= bus_if.iFirst;
                s0_warm_q  <= cur_warm;
                s0_order_q <= cur_order;
                s0_x_q[0]  <= bus_if.iSample;
                for (int i = 1; i <= 4; i++) s0_x_q[i] <= cur_hist[i];
            end
        end
    end

    // Shift-and-add coefficient terms; warm-up keeps only x[n] so the sum is the sample.
    always_comb begin
        for (int i = 0; i <= 4; i++) begin
            xe[i]  = sext(s0_x_q[i]);
            t_d[i] = '0;
        end
        t_d[0] = xe[0];
        if (!s0_warm_q) begin
            case (s0_order_q)
                3'd1: begin
                    t_d[1] = -xe[1];
                end
                3'd2: begin
                    t_d[1] = -(xe[1] <<< 1);
                    t_d[2] = xe[2];
                end
                3'd3: begin
                    t_d[1] = -((xe[1] <<< 1) + xe[1]);
                    t_d[2] = (xe[2] <<< 1) + xe[2];
                    t_d[3] = -xe[3];
                end
                3'd4: begin
                    t_d[1] = -(xe[1] <<< 2);
                    t_d[2] = (xe[2] <<< 2) + (xe[2] <<< 1);
                    t_d[3] = -(xe[3] <<< 2);
                    t_d[4] = xe[4];
                end
                default: ;
            endcase
        end
    end

    // Stages 1-3: register terms, sum them, register the output.
    always_ff @(posedge iClock) begin
        if (iReset) begin
            s1_valid_q  <= 1'b0;
            s1_first_q  <= 1'b0;
            s1_warm_q   <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_first_q  <= 1'b0;
            s2_warm_q   <= 1'b0;
            s2_sum_q    <= '0;
            out_valid_q <= 1'b0;
            out_first_q <= 1'b0;
            out_warm_q  <= 1'b0;
            out_res_q   <= '0;
            for (int i = 0; i <= 4; i++) s1_t_q[i] <= '0;
        end else begin
            s1_valid_q <= s0_valid_q;
            s1_first_q <= s0_first_q;
            s1_warm_q  <= s0_warm_q;
            for (int i = 0; i <= 4; i++) s1_t_q[i] <= t_d[i];

            s2_valid_q <= s1_valid_q;
            s2_first_q <= s1_first_q;
            s2_warm_q  <= s1_warm_q;
            s2_sum_q   <= s1_t_q[0] + s1_t_q[1] + s1_t_q[2] + s1_t_q[3] + s1_t_q[4];

            out_valid_q <= s2_valid_q;
            out_first_q <= s2_valid_q & s2_first_q;
            out_warm_q  <= s2_valid_q & s2_warm_q;
            if (s2_valid_q) out_res_q <= s2_sum_q;
        end
    end

    assign bus_if.oValid    = out_valid_q;
    assign bus_if.oFirst    = out_first_q;
    assign bus_if.oWarmup   = out_warm_q;
    assign bus_if.oResidual = out_res_q;
endmodule

// File: tb/tb_fixed_predictor_encoder.sv
// Directed bench for fixed_predictor_encoder (SAMPLE_WIDTH=16, 20-bit residuals).
`timescale 1ns/1ps
module tb_fixed_predictor_encoder;
    localparam int SW = 16;
    localparam int RW = SW + 4;
    localparam int W  = RW + 2;   // {first, warmup, residual}

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] obs_q[$];
    int           obs_cyc_q[$];
    int           in_cyc_q[$];

    fixed_predictor_encoder_if #(.SAMPLE_WIDTH(SW)) bus();

    fixed_predictor_encoder #(.SAMPLE_WIDTH(SW)) dut (
        .iClock (clk),
        .iReset (rst),
        .bus_if (bus)
    );

    // Clock and cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Output collector, sampled on the falling edge
    always @(negedge clk) begin
        if (bus.oValid === 1'b1) begin
            obs_q.push_back({bus.oFirst, bus.oWarmup, bus.oResidual});
            obs_cyc_q.push_back(cyc);
        end
    end

    function automatic logic [W-1:0] mk(input int f, input int w, input int r);
        logic [31:0] rv;
        logic [31:0] fv;
        logic [31:0] wv;
        rv = r;
        fv = f;
        wv = w;
        return {fv[0], wv[0], rv[RW-1:0]};
    endfunction

    // Driver: apply one cycle of input just after the rising edge
    task automatic drive(input int v, input int f, input int o, input int s);
        logic [31:0] sv;
        logic [31:0] ov;
        logic [31:0] vv;
        logic [31:0] fv;
        sv = s;
        ov = o;
        vv = v;
        fv = f;
        @(posedge clk);
        #1;
        bus.iValid  = vv[0];
        bus.iFirst  = fv[0];
        bus.iOrder  = ov[2:0];
        bus.iSample = sv[SW-1:0];
        if (vv[0]) in_cyc_q.push_back(cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) drive(0, 0, 0, 0);
    endtask

    task automatic clear_sb();
        exp_q.delete();
        obs_q.delete();
        obs_cyc_q.delete();
        in_cyc_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iValid = 1'b0; bus.iFirst = 1'b0; bus.iOrder = 3'd0; bus.iSample = '0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.oValid, bus.oFirst, bus.oWarmup} !== 3'b000 || bus.oResidual !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got v=%b f=%b w=%b res=%0d, expected all 0",
                     bus.oValid, bus.oFirst, bus.oWarmup, bus.oResidual);
        end
        rst = 1'b0;
        clear_sb();
        // samples before any iFirst: order 0, no warm-up
        drive(1, 0, 3, 3);
        drive(1, 0, 3, -4);
        idle(8);
        exp_q = '{mk(0, 0, 3), mk(0, 0, -4)};
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL pre_first_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL pre_first_out[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_order3();
        clear_sb();
        drive(1, 1, 3, 10);
        drive(1, 0, 3, 20);
        drive(1, 0, 3, 30);
        drive(1, 0, 3, 40);
        drive(1, 0, 3, 50);
        idle(8);
        exp_q = '{mk(1, 1, 10), mk(0, 1, 20), mk(0, 1, 30), mk(0, 0, 0), mk(0, 0, 0)};
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL order3_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL order3_out[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
                end
                n_checks++;
                if (obs_cyc_q[i] !== in_cyc_q[i] + 4) begin
                    n_fail++;
                    $display("FAIL order3_latency[%0d]: got cycle %0d, expected %0d", i, obs_cyc_q[i], in_cyc_q[i] + 4);
                end
            end
        end
    endtask

    task automatic test_gaps_order2();
        clear_sb();
        // invalid cycles carry iFirst=1/order 0, which must be ignored
        drive(1, 1, 2, 0);  drive(0, 1, 0, 99);
        drive(1, 0, 2, 1);  drive(0, 1, 0, 99);
        drive(1, 0, 2, 4);  drive(0, 1, 0, 99);
        drive(1, 0, 2, 9);  drive(0, 1, 0, 99);
        drive(1, 0, 2, 16); drive(0, 1, 0, 99);
        drive(1, 0, 2, 25);
        idle(8);
        exp_q = '{mk(1, 1, 0), mk(0, 1, 1), mk(0, 0, 2), mk(0, 0, 2), mk(0, 0, 2), mk(0, 0, 2)};
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL gaps_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL gaps_out[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
                end
                n_checks++;
                if (obs_cyc_q[i] !== in_cyc_q[i] + 4) begin
                    n_fail++;
                    $display("FAIL gaps_timing[%0d]: got cycle %0d, expected %0d", i, obs_cyc_q[i], in_cyc_q[i] + 4);
                end
            end
        end
    endtask

    task automatic test_order4_extremes();
        clear_sb();
        drive(1, 1, 4, 32767);
        drive(1, 0, 4, -32768);
        drive(1, 0, 4, 32767);
        drive(1, 0, 4, -32768);
        drive(1, 0, 4, 32767);
        idle(8);
        exp_q = '{mk(1, 1, 32767), mk(0, 1, -32768), mk(0, 1, 32767), mk(0, 1, -32768), mk(0, 0, 524280)};
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL extremes_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL extremes_out[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_block_switch();
        clear_sb();
        drive(1, 1, 4, 1);
        drive(1, 0, 4, 2);
        drive(1, 0, 4, 4);
        drive(1, 0, 4, 8);
        drive(1, 0, 4, 16);
        drive(1, 0, 4, 32);
        drive(1, 1, 1, 100);
        drive(1, 0, 1, 103);
        idle(8);
        exp_q = '{mk(1, 1, 1), mk(0, 1, 2), mk(0, 1, 4), mk(0, 1, 8), mk(0, 0, 1), mk(0, 0, 2),
                  mk(1, 1, 100), mk(0, 0, 3)};
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL switch_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL switch_out[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_order_clamp();
        clear_sb();
        drive(1, 1, 7, 1);
        for (int s = 2; s <= 6; s++) drive(1, 0, 7, s);
        idle(8);
        exp_q = '{mk(1, 1, 1), mk(0, 1, 2), mk(0, 1, 3), mk(0, 1, 4), mk(0, 0, 0), mk(0, 0, 0)};
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL clamp_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL clamp_out[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_sb();
        drive(1, 1, 1, 5);
        drive(1, 1, 1, 7);
        drive(1, 1, 0, -3);
        drive(1, 0, 2, 11);
        idle(8);
        exp_q = '{mk(1, 1, 5), mk(1, 1, 7), mk(1, 0, -3), mk(0, 0, 11)};
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL b2b_out[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
                end
                n_checks++;
                if (obs_cyc_q[i] !== in_cyc_q[i] + 4) begin
                    n_fail++;
                    $display("FAIL b2b_timing[%0d]: got cycle %0d, expected %0d", i, obs_cyc_q[i], in_cyc_q[i] + 4);
                end
            end
        end
    endtask

    task automatic test_reset_mid_block();
        clear_sb();
        drive(1, 1, 1, 50);
        drive(1, 0, 1, 60);
        @(posedge clk);
        #1;
        bus.iValid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        n_checks++;
        if (bus.oValid !== 1'b0 || bus.oResidual !== '0) begin
            n_fail++;
            $display("FAIL midreset_state: got v=%b res=%0d, expected v=0 res=0", bus.oValid, bus.oResidual);
        end
        in_cyc_q.delete();
        // no iFirst after reset: order 0 even though iOrder says 3
        drive(1, 0, 3, 7);
        drive(1, 0, 3, -9);
        idle(8);
        exp_q = '{mk(0, 0, 7), mk(0, 0, -9)};
        n_checks++;
        if (obs_q.size() !== exp_q.size()) begin
            n_fail++;
            $display("FAIL midreset_count: got %0d outputs, expected %0d", obs_q.size(), exp_q.size());
        end
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < obs_q.size()) begin
                n_checks++;
                if (obs_q[i] !== exp_q[i]) begin
                    n_fail++;
                    $display("FAIL midreset_out[%0d]: got %h, expected %h", i, obs_q[i], exp_q[i]);
                end
                n_checks++;
                if (obs_cyc_q[i] !== in_cyc_q[i] + 4) begin
                    n_fail++;
                    $display("FAIL midreset_timing[%0d]: got cycle %0d, expected %0d", i, obs_cyc_q[i], in_cyc_q[i] + 4);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_order3();
        test_gaps_order2();
        test_order4_extremes();
        test_block_switch();
        test_order_clamp();
        test_back_to_back();
        test_reset_mid_block();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/fixed_predictor_encoder.md
# fixed_predictor_encoder

Parametrised FLAC fixed-predictor residual encoder. It supports all five fixed orders (0–4), selected per block at run time. The sample width is configurable, and the residual output is widened so it never overflows. A valid-qualified streaming interface accepts one sample per clock with arbitrary gaps. The block sits between the sample framer and the residual/Rice coder, and replaces the single-order, fixed-width encoders. Warm-up samples are flagged and passed through verbatim so the downstream coder can emit them unencoded.

## Interface
- SAMPLE_WIDTH, 16, signed input sample width (8–32).
- RES_WIDTH (localparam), SAMPLE_WIDTH+4, signed residual width; covers the worst-case order-4 magnitude of 2^(SAMPLE_WIDTH+3)−8.
- iClock  in  1  clock; all logic on the rising edge.
- iReset  in  1  synchronous, active-high reset.
- iValid  in  1  iSample is valid this cycle.
- iFirst  in  1  first sample of a new block; qualified by iValid.
- iOrder  in  3  predictor order for the block; sampled only when iValid & iFirst.
- iSample  in  SAMPLE_WIDTH  signed sample.
- oValid  out  1  oResidual is valid.
- oFirst  out  1  output corresponds to a block's first sample.
- oWarmup  out  1  output is a verbatim warm-up sample.
- oResidual  out  RES_WIDTH  signed residual, or the sign-extended warm-up sample.

## Operation
- Per-block state:
  - order register: 0–4; iOrder values 5–7 clamp to 4.
  - history x[n−1..n−4].
  - warm-up down-counter.
- Block start (iValid & iFirst):
  - latch the order;
  - clear the history to 0;
  - load the warm-up counter with the order.
  - The current sample then follows the normal warm-up/residual rule below using the new state.
- Warm-up rule:
  - While the counter is non-zero, a valid sample is output with oWarmup=1 and oResidual=sext(x[n]); the counter decrements.
  - Order 0 has no warm-up.
- Residual formulas, all in RES_WIDTH arithmetic, exact, no saturation:
  - 0: x[n]
  - 1: x[n]−x[n−1]
  - 2: x[n]−2x[n−1]+x[n−2]
  - 3: x[n]−3x[n−1]+3x[n−2]−x[n−3]
  - 4: x[n]−4x[n−1]+6x[n−2]−4x[n−3]+x[n−4]
- Multiplies are implemented as shift-and-add. No multipliers are inferred.
- History shifts only on iValid. Cycles with iValid=0 leave all block state untouched.
- Order, warm-up flag and first flag travel down the pipeline with each sample.
  - An iFirst arriving while an older block is still in flight does not alter in-flight results.
- iFirst with iValid=0 is ignored.
- Samples arriving after reset but before any iFirst are encoded as order 0, non-warm-up.
- No backpressure: the consumer must accept every oValid cycle.

## Timing
- Fully pipelined, throughput 1 sample/cycle. Latency is 4 register stages, independent of order:
  - edge N: input/history capture, from the sample presented with iValid;
  - N+1: partial terms;
  - N+2: sum;
  - N+3: output register.
- oValid/oFirst/oWarmup/oResidual update at edge N+3 and hold for one cycle. oValid is low on cycles with no matching input.
- Gaps propagate unchanged: the output valid pattern equals the input valid pattern delayed by 4 cycles.
- Reset: at the iReset edge, the following are all forced to 0, with oValid low from the following cycle:
  - all outputs;
  - pipeline valids;
  - history, order and warm-up counter.
- Reset mid-block discards in-flight samples; no stale oValid is ever produced.
- Back-to-back blocks (iFirst on consecutive valid samples): each sample is treated as a fresh block; no bubbles.

## Test plan
- SAMPLE_WIDTH=16, order 3, block 10,20,30,40,50 on consecutive cycles -> outputs 4 cycles later: 10,20,30 with oWarmup=1 (oFirst on 10), then 0,0 with oWarmup=0.
- Order 2, samples 0,1,4,9,16,25 with iValid low on every other cycle -> warm-up 0,1 then residuals 2,2,2,2; oValid has the same gap pattern 4 cycles delayed.
- Order 4 extremes 32767,−32768,32767,−32768,32767 -> fifth output 524280 (20-bit), no wrap.
- Order 4 block of 6 samples, then iFirst order 1 with 100,103 -> second block outputs 100 (warm-up, oFirst), 3; first block's residuals unaffected.
- iOrder=7 on iFirst with samples 1,2,3,4,5,6 -> 4 warm-ups, then residual 0 (clamped to order 4).
- iReset asserted two cycles into an order-1 block -> no oValid for any pre-reset sample; post-reset samples without iFirst give oResidual=sample, oWarmup=0.
